// File: rtl/fft_butterfly_engine.sv
// Radix-2 in-place butterfly engine: 4-stage pipeline (read, multiply, add/scale, write-back)
// with start/busy/done run control and a drain stall at every FFT level boundary.
module fft_butterfly_engine #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned TW_W        = 16,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned TWID_ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   input  logic                   agu_valid,
   output logic                   agu_ready,
   input  logic [ADDR_W-1:0]      agu_ja,
   input  logic [ADDR_W-1:0]      agu_jb,
   input  logic [TWID_ADDR_W-1:0] agu_twiddle_addr,
   input  logic                   agu_level_last,
   input  logic                   agu_last,
   output logic [ADDR_W-1:0]      mem_rd_addr_a,
   output logic [ADDR_W-1:0]      mem_rd_addr_b,
   input  logic [2*DATA_W-1:0]    mem_rd_data_a,
   input  logic [2*DATA_W-1:0]    mem_rd_data_b,
   output logic [TWID_ADDR_W-1:0] tw_addr,
   input  logic [2*TW_W-1:0]      tw_data,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_wr_addr_a,
   output logic [ADDR_W-1:0]      mem_wr_addr_b,
   output logic [2*DATA_W-1:0]    mem_wr_data_a,
   output logic [2*DATA_W-1:0]    mem_wr_data_b
);
   localparam int unsigned PW = DATA_W + TW_W;
   localparam int unsigned WW = DATA_W + 2;
   localparam logic signed [WW-1:0] SatMax = WW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [WW-1:0] SatMin = ~SatMax;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFlush} state_e;

   typedef struct packed {
      logic              lvl_last;
      logic              last;
      logic [ADDR_W-1:0] ja;
      logic [ADDR_W-1:0] jb;
   } tag_t;

   state_e state_q, state_d;
   logic   done_q, done_d;
   logic   accept;

   // vld_q[k] / tag_q[k] describe the butterfly sitting in pipeline stage k+1
   logic [3:0] vld_q, vld_d;
   tag_t       tag_q [4];
   tag_t       tag_d [4];

   logic [2*DATA_W-1:0]    a2_q, a2_d, b2_q, b2_d, a3_q, a3_d;
   logic [2*TW_W-1:0]      w2_q, w2_d;
   logic signed [PW-1:0]   prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;
   logic [2*DATA_W-1:0]    wa_q, wa_d, wb_q, wb_d;

   logic signed [DATA_W-1:0] b_re, b_im, a_re, a_im;
   logic signed [TW_W-1:0]   w_re, w_im;
   logic signed [WW-1:0]     wb_re, wb_im, a_re_x, a_im_x;

   assign b_re = b2_q[2*DATA_W-1:DATA_W];
   assign b_im = b2_q[DATA_W-1:0];
   assign w_re = w2_q[2*TW_W-1:TW_W];
   assign w_im = w2_q[TW_W-1:0];
   assign a_re = a3_q[2*DATA_W-1:DATA_W];
   assign a_im = a3_q[DATA_W-1:0];

   function automatic logic [DATA_W-1:0] sat_half(input logic signed [WW-1:0] s);
      logic signed [WW-1:0] h;
      h = s >>> 1;
      if (h > SatMax) return SatMax[DATA_W-1:0];
      if (h < SatMin) return SatMin[DATA_W-1:0];
      return h[DATA_W-1:0];
   endfunction

   assign mem_rd_addr_a = agu_ja;
   assign mem_rd_addr_b = agu_jb;
   assign tw_addr       = agu_twiddle_addr;
   assign accept        = agu_valid & agu_ready;
   assign busy          = (state_q != StIdle);
   assign done          = done_q;
   assign mem_we        = vld_q[3];
   assign mem_wr_addr_a = tag_q[3].ja;
   assign mem_wr_addr_b = tag_q[3].jb;
   assign mem_wr_data_a = wa_q;
   assign mem_wr_data_b = wb_q;

   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      agu_ready = (state_q == StRun);
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun: begin
            if (accept) begin
               if (agu_last)            state_d = StFlush;
               else if (agu_level_last) state_d = StDrain;
            end
         end
         // Hold off reads until the level's final write has reached the RAM
         StDrain: if (vld_q[3] && tag_q[3].lvl_last) state_d = StRun;
         StFlush: begin
            if (vld_q[3] && tag_q[3].last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      vld_d    = {vld_q[2:0], accept};
      tag_d[0] = accept ? {agu_level_last, agu_last, agu_ja, agu_jb} : tag_q[0];
      for (int k = 1; k < 4; k++) begin
         tag_d[k] = vld_q[k-1] ? tag_q[k-1] : tag_q[k];
      end

      a2_d = vld_q[0] ? mem_rd_data_a : a2_q;
      b2_d = vld_q[0] ? mem_rd_data_b : b2_q;
      w2_d = vld_q[0] ? tw_data       : w2_q;

      a3_d  = vld_q[1] ? a2_q : a3_q;
      prr_d = vld_q[1] ? PW'(b_re) * PW'(w_re) : prr_q;
      pii_d = vld_q[1] ? PW'(b_im) * PW'(w_im) : pii_q;
      pri_d = vld_q[1] ? PW'(b_re) * PW'(w_im) : pri_q;
      pir_d = vld_q[1] ? PW'(b_im) * PW'(w_re) : pir_q;

      // Truncating shift back to Q0 leaves WB exactly WW bits wide
      wb_re  = WW'((prr_q - pii_q) >>> (TW_W - 2));
      wb_im  = WW'((pri_q + pir_q) >>> (TW_W - 2));
      a_re_x = WW'(a_re);
      a_im_x = WW'(a_im);
      wa_d   = vld_q[2] ? {sat_half(a_re_x + wb_re), sat_half(a_im_x + wb_im)} : wa_q;
      wb_d   = vld_q[2] ? {sat_half(a_re_x - wb_re), sat_half(a_im_x - wb_im)} : wb_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
         vld_q   <= '0;
         for (int k = 0; k < 4; k++) tag_q[k] <= '0;
         a2_q  <= '0;
         b2_q  <= '0;
         w2_q  <= '0;
         a3_q  <= '0;
         prr_q <= '0;
         pii_q <= '0;
         pri_q <= '0;
         pir_q <= '0;
         wa_q  <= '0;
         wb_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         vld_q   <= vld_d;
         for (int k = 0; k < 4; k++) tag_q[k] <= tag_d[k];
         a2_q  <= a2_d;
         b2_q  <= b2_d;
         w2_q  <= w2_d;
         a3_q  <= a3_d;
         prr_q <= prr_d;
         pii_q <= pii_d;
         pri_q <= pri_d;
         pir_q <= pir_d;
         wa_q  <= wa_d;
         wb_q  <= wb_d;
      end
   end

endmodule
